// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Hazard and stall sequencer for a 5-stage RISC-V pipeline.
//               Sits beside ID and consumes EX-stage status. Resolves
//               load-use hazards, taken-branch flushes, instruction-memory
//               wait states and multi-cycle MUL/DIV operations. Also keeps
//               a saturating count of cycles in which the PC did not load.
//
// Ports       : clk             rising-edge clock
//               reset_n         synchronous active-low reset
//               id_rs1/id_rs2   source registers of the ID instruction
//               id_uses_rs1/2   ID instruction reads rs1/rs2
//               id_is_mdu       ID instruction is MUL/DIV
//               ex_mem_read     EX instruction is a load
//               ex_rd           destination of the EX instruction
//               ex_branch_taken EX branch/jump resolved taken
//               imem_ready      instruction memory data valid this cycle
//               mdu_done        MDU result valid (one-cycle pulse)
//               pc_write        PC load enable
//               if_id_stall     hold IF/ID contents
//               if_id_flush     clear IF/ID to NOP
//               id_ex_bubble    load NOP into ID/EX
//               mdu_start       one-cycle MDU launch pulse
//               mdu_timeout     sticky MDU timeout error flag
//               stall_count     saturating count of pc_write=0 cycles
//
// Revision    : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MDU_TIMEOUT = 64,   // 2..255
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_is_mdu,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    input  logic             mdu_done,
    output logic             pc_write,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             mdu_start,
    output logic             mdu_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MDU_WAIT = 1'b1;

    // Wait-cycle count value at which the MDU is abandoned; the wait state is
    // entered with the counter at 0, so this lands MDU_TIMEOUT cycles after
    // the issue cycle.
    localparam logic [7:0] TMO_LAST = 8'(MDU_TIMEOUT - 1);

    logic [0:0]       state_q,       state_d;
    logic [7:0]       tmo_cnt_q,     tmo_cnt_d;
    logic             mdu_timeout_q, mdu_timeout_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic w_load_use;
    logic w_pc_write;
    logic w_stall;
    logic w_flush;
    logic w_bubble;
    logic w_mdu_start;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                        ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                         (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        w_pc_write    = 1'b1;
        w_stall       = 1'b0;
        w_flush       = 1'b0;
        w_bubble      = 1'b0;
        w_mdu_start   = 1'b0;
        state_d       = state_q;
        tmo_cnt_d     = tmo_cnt_q;
        mdu_timeout_d = mdu_timeout_q;

        case (state_q)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    // ID holds a wrong-path instruction: squash it regardless
                    // of any hazard it would otherwise raise.
                    w_pc_write = 1'b1;
                    w_flush    = 1'b1;
                    w_bubble   = 1'b1;
                end else if (w_load_use) begin
                    w_pc_write = 1'b0;
                    w_stall    = 1'b1;
                    w_bubble   = 1'b1;
                end else if (id_is_mdu) begin
                    w_mdu_start = 1'b1;
                    w_pc_write  = 1'b0;
                    w_stall     = 1'b1;
                    w_bubble    = 1'b1;
                    tmo_cnt_d   = 8'd0;
                    state_d     = ST_MDU_WAIT;
                end else if (!imem_ready) begin
                    // The ID instruction moves on; a NOP takes its place.
                    w_pc_write = 1'b0;
                    w_flush    = 1'b1;
                end
            end

            ST_MDU_WAIT: begin
                if (mdu_done || (tmo_cnt_q == TMO_LAST)) begin
                    // Release the MDU instruction into EX.
                    w_pc_write = imem_ready;
                    w_flush    = !imem_ready;
                    state_d    = ST_RUN;
                    if (!mdu_done) begin
                        mdu_timeout_d = 1'b1;
                    end
                end else begin
                    w_pc_write = 1'b0;
                    w_stall    = 1'b1;
                    w_bubble   = 1'b1;
                    tmo_cnt_d  = tmo_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!w_pc_write && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_RUN;
            tmo_cnt_q     <= 8'd0;
            mdu_timeout_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            tmo_cnt_q     <= tmo_cnt_d;
            mdu_timeout_q <= mdu_timeout_d;
            stall_count_q <= stall_count_d;
        end
    end

    // During reset the pipeline is held flushed; otherwise flush beats stall.
    always_comb begin
        if (!reset_n) begin
            pc_write     = 1'b0;
            if_id_stall  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            mdu_start    = 1'b0;
        end else begin
            pc_write     = w_pc_write;
            if_id_stall  = w_stall && !w_flush;
            if_id_flush  = w_flush;
            id_ex_bubble = w_bubble;
            mdu_start    = w_mdu_start;
        end
    end

    assign mdu_timeout = mdu_timeout_q;
    assign stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl. A behavioural
//               model tracks "cycles since MDU issue" and a plain integer
//               stall tally; a negedge process compares every output each
//               cycle, and the directed sequence pins key literal values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int TMO = 8;
    localparam int CW  = 6;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, id_is_mdu;
    logic          ex_mem_read, ex_branch_taken, imem_ready, mdu_done;
    logic          pc_write, if_id_stall, if_id_flush, id_ex_bubble;
    logic          mdu_start, mdu_timeout;
    logic [CW-1:0] stall_count;

    pipeline_hazard_ctrl #(.MDU_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_is_mdu(id_is_mdu), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
        .mdu_done(mdu_done), .pc_write(pc_write), .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .mdu_start(mdu_start), .mdu_timeout(mdu_timeout),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit check_en = 1'b0;
    bit m_busy   = 1'b0;   // an MDU operation is outstanding
    int m_since  = 0;      // cycles elapsed since the issue cycle
    bit m_tmo    = 1'b0;
    int m_cnt    = 0;
    bit n_busy, n_tmo;
    int n_since, n_cnt;
    bit e_pw, e_st, e_fl, e_bub, e_ms, hazard;

    always @(negedge clk) begin
        if (check_en) begin
            e_pw = 1'b1; e_st = 1'b0; e_fl = 1'b0; e_bub = 1'b0; e_ms = 1'b0;
            n_busy = m_busy; n_since = m_since; n_tmo = m_tmo;
            hazard = ex_mem_read && ex_rd != 0 &&
                     ((id_uses_rs1 && id_rs1 == ex_rd) ||
                      (id_uses_rs2 && id_rs2 == ex_rd));
            if (!reset_n) begin
                e_pw = 0; e_fl = 1; e_bub = 1;
                n_busy = 0; n_since = 0; n_tmo = 0;
            end else if (!m_busy) begin
                if (ex_branch_taken) begin
                    e_fl = 1; e_bub = 1;
                end else if (hazard) begin
                    e_pw = 0; e_st = 1; e_bub = 1;
                end else if (id_is_mdu) begin
                    e_ms = 1; e_pw = 0; e_st = 1; e_bub = 1;
                    n_busy = 1; n_since = 1;
                end else if (!imem_ready) begin
                    e_pw = 0; e_fl = 1;
                end
            end else begin
                if (mdu_done || m_since == TMO) begin
                    e_pw = imem_ready; e_fl = !imem_ready;
                    n_busy = 0;
                    if (!mdu_done) n_tmo = 1;
                end else begin
                    e_pw = 0; e_st = 1; e_bub = 1;
                    n_since = m_since + 1;
                end
            end
            if (!reset_n)  n_cnt = 0;
            else if (!e_pw) n_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            else            n_cnt = m_cnt;

            chk("pc_write",     32'(pc_write),     32'(e_pw));
            chk("if_id_stall",  32'(if_id_stall),  32'(e_st));
            chk("if_id_flush",  32'(if_id_flush),  32'(e_fl));
            chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
            chk("mdu_start",    32'(mdu_start),    32'(e_ms));
            chk("mdu_timeout",  32'(mdu_timeout),  32'(m_tmo));
            chk("stall_count",  32'(stall_count),  32'(m_cnt));
        end
    end

    always @(posedge clk) begin
        if (check_en) begin
            m_busy  <= n_busy;
            m_since <= n_since;
            m_tmo   <= n_tmo;
            m_cnt   <= n_cnt;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        reset_n = 1; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_is_mdu = 0; ex_mem_read = 0; ex_rd = 0; ex_branch_taken = 0;
        imem_ready = 1; mdu_done = 0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        cyc(); idle(); reset_n = 0;
        settle();
        chk("lit_rst_pc_write", 32'(pc_write), 32'd0);
        chk("lit_rst_flush",    32'(if_id_flush), 32'd1);
        cyc(); idle();
    endtask

    initial begin
        idle();
        reset_n = 0;
        @(posedge clk); #1;
        check_en = 1;
        settle();
        chk("lit_reset_cnt", 32'(stall_count), 32'd0);
        chk("lit_reset_tmo", 32'(mdu_timeout), 32'd0);

        // plain run
        cyc(); idle(); settle();
        chk("lit_run_pc_write", 32'(pc_write), 32'd1);

        // load-use on rs2 = x5
        cyc(); ex_mem_read = 1; ex_rd = 5; id_uses_rs2 = 1; id_rs2 = 5; settle();
        chk("lit_lu_pc_write", 32'(pc_write), 32'd0);
        chk("lit_lu_stall",    32'(if_id_stall), 32'd1);
        chk("lit_lu_bubble",   32'(id_ex_bubble), 32'd1);
        cyc(); ex_mem_read = 0; settle();
        chk("lit_lu_after_pc", 32'(pc_write), 32'd1);

        // load into x0, ID reads x0: no hazard
        cyc(); idle(); ex_mem_read = 1; ex_rd = 0; id_uses_rs1 = 1; id_rs1 = 0; settle();
        chk("lit_x0_pc_write", 32'(pc_write), 32'd1);

        // load-use plus taken branch: flush wins
        cyc(); idle(); ex_mem_read = 1; ex_rd = 5; id_uses_rs2 = 1; id_rs2 = 5;
        ex_branch_taken = 1; settle();
        chk("lit_br_flush", 32'(if_id_flush), 32'd1);
        chk("lit_br_stall", 32'(if_id_stall), 32'd0);
        chk("lit_br_pc",    32'(pc_write), 32'd1);

        // MDU with done after three wait cycles; done on issue cycle ignored
        do_reset();
        id_is_mdu = 1; mdu_done = 1; settle();
        chk("lit_mdu_start", 32'(mdu_start), 32'd1);
        cyc(); idle(); id_is_mdu = 1;
        cyc(); idle(); ex_branch_taken = 1; settle();
        chk("lit_mdu_ign_br_flush", 32'(if_id_flush), 32'd0);
        chk("lit_mdu_ign_br_start", 32'(mdu_start), 32'd0);
        cyc(); idle();
        cyc(); idle(); mdu_done = 1; settle();
        chk("lit_mdu_done_bubble", 32'(id_ex_bubble), 32'd0);
        chk("lit_mdu_done_pc",     32'(pc_write), 32'd1);
        chk("lit_mdu_cnt4",        32'(stall_count), 32'd4);
        cyc(); idle(); settle();
        chk("lit_mdu_post_start", 32'(mdu_start), 32'd0);

        // MDU timeout: exit 8 cycles after issue, flag sticky
        do_reset();
        id_is_mdu = 1;
        for (int i = 1; i < TMO; i++) begin
            cyc(); idle(); settle();
            chk("lit_tmo_wait_pc", 32'(pc_write), 32'd0);
        end
        cyc(); idle(); settle();
        chk("lit_tmo_exit_pc",  32'(pc_write), 32'd1);
        chk("lit_tmo_exit_bub", 32'(id_ex_bubble), 32'd0);
        cyc(); idle(); settle();
        chk("lit_tmo_flag", 32'(mdu_timeout), 32'd1);
        repeat (3) cyc();
        settle();
        chk("lit_tmo_sticky", 32'(mdu_timeout), 32'd1);

        // imem wait for two cycles
        for (int i = 0; i < 2; i++) begin
            cyc(); idle(); imem_ready = 0; settle();
            chk("lit_imem_pc",  32'(pc_write), 32'd0);
            chk("lit_imem_fl",  32'(if_id_flush), 32'd1);
            chk("lit_imem_bub", 32'(id_ex_bubble), 32'd0);
        end

        // reset while in MDU_WAIT with stall_count = 10
        do_reset();
        imem_ready = 0;
        repeat (7) begin cyc(); idle(); imem_ready = 0; end
        cyc(); idle(); id_is_mdu = 1;
        cyc(); idle();
        cyc(); idle(); settle();
        chk("lit_mid_cnt10", 32'(stall_count), 32'd10);
        reset_n = 0;
        cyc(); idle(); settle();
        chk("lit_mid_cnt0",   32'(stall_count), 32'd0);
        chk("lit_mid_tmo0",   32'(mdu_timeout), 32'd0);
        chk("lit_mid_nostart", 32'(mdu_start), 32'd0);
        chk("lit_mid_pc",     32'(pc_write), 32'd1);

        // counter saturation
        repeat (70) begin cyc(); idle(); imem_ready = 0; end
        cyc(); idle(); settle();
        chk("lit_sat", 32'(stall_count), 32'(CNT_MAX));

        cyc();
        check_en = 0;
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
